// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
//
// Shares one water tank between a sprinkler zone and a dripper zone. The
// two zone requests are arbitrated round-robin, and each granted run is
// timed in ticks of the slow time base. If the tank runs dry mid-run, the
// run pauses in FILL with its remaining time kept. It resumes once the
// tank reports full. A fill that never completes, or contradictory level
// sensors, lock the block into FAULT until reset.
//
// Ports:
//   clock, reset                  system clock, asynchronous active-high reset
//   tick                          one-cycle time-base strobe; all timing counts ticks
//   full_tank, empty_tank         tank level sensors
//   splinker_req, dripper_req     level-sensitive zone run requests
//   splinker_time, dripper_time   run lengths in ticks, sampled at grant
//   abort                         cancels the current run or fill
//   fill_valve                    tank inlet valve open (FILL)
//   splinker, dripper             zone valves open (RUN_S / RUN_D)
//   busy                          any state other than IDLE
//   remaining                     ticks left in the current run
//   fault                         sticky fault indication (FAULT)

module irrigation_scheduler #(
    parameter int TIME_W       = 8,
    parameter int FILL_TIMEOUT = 60
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              full_tank,
    input  logic              empty_tank,
    input  logic              splinker_req,
    input  logic              dripper_req,
    input  logic [TIME_W-1:0] splinker_time,
    input  logic [TIME_W-1:0] dripper_time,
    input  logic              abort,
    output logic              fill_valve,
    output logic              splinker,
    output logic              dripper,
    output logic              busy,
    output logic [TIME_W-1:0] remaining,
    output logic              fault
);

    localparam int CNT_W = $clog2(FILL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN_S = 3'd2,
        RUN_D = 3'd3,
        FAULT = 3'd4
    } state_t;

    typedef enum logic {
        ZONE_S = 1'b0,
        ZONE_D = 1'b1
    } zone_t;

    state_t            state_q, state_d;
    zone_t             zone_q, zone_d;
    zone_t             last_served_q, last_served_d;
    logic [TIME_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;

    logic  elig_s, elig_d, grant_valid;
    zone_t grant_zone;

    // A request with a zero run length is never eligible, so it can never
    // open a valve. With both zones eligible, the zone not served last wins.
    always_comb begin
        elig_s      = splinker_req && (splinker_time != '0);
        elig_d      = dripper_req && (dripper_time != '0);
        grant_valid = elig_s || elig_d;
        grant_zone  = ZONE_S;
        if (elig_s && elig_d) begin
            grant_zone = (last_served_q == ZONE_S) ? ZONE_D : ZONE_S;
        end else if (elig_d) begin
            grant_zone = ZONE_D;
        end
    end

    function automatic state_t runStateOf(input zone_t z);
        return (z == ZONE_S) ? RUN_S : RUN_D;
    endfunction

    // Next-state logic. FAULT is absorbing. Contradictory sensors come next,
    // then abort, then the per-state transitions.
    always_comb begin
        state_d       = state_q;
        zone_d        = zone_q;
        last_served_d = last_served_q;
        remaining_d   = remaining_q;
        fill_cnt_d    = fill_cnt_q;

        if (state_q == FAULT) begin
            remaining_d = '0;
        end else if (full_tank && empty_tank) begin
            state_d     = FAULT;
            remaining_d = '0;
        end else if (abort) begin
            // An interrupted run still counts as served for round-robin.
            if ((state_q == FILL) || (state_q == RUN_S) || (state_q == RUN_D)) begin
                last_served_d = zone_q;
            end
            state_d     = IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        zone_d      = grant_zone;
                        remaining_d = (grant_zone == ZONE_S) ? splinker_time : dripper_time;
                        fill_cnt_d  = '0;
                        state_d     = full_tank ? runStateOf(grant_zone) : FILL;
                    end
                end
                FILL: begin
                    // A full tank wins over a timeout tick in the same cycle.
                    if (full_tank) begin
                        state_d = runStateOf(zone_q);
                    end else if (tick) begin
                        if (fill_cnt_q == CNT_W'(FILL_TIMEOUT - 1)) begin
                            state_d     = FAULT;
                            remaining_d = '0;
                        end else begin
                            fill_cnt_d = fill_cnt_q + CNT_W'(1);
                        end
                    end
                end
                RUN_S, RUN_D: begin
                    // A completing tick beats an empty tank. A non-completing
                    // tick still consumes its time before the run pauses.
                    if (tick && (remaining_q == TIME_W'(1))) begin
                        state_d       = IDLE;
                        remaining_d   = '0;
                        last_served_d = zone_q;
                    end else begin
                        if (tick) begin
                            remaining_d = remaining_q - TIME_W'(1);
                        end
                        if (empty_tank) begin
                            state_d    = FILL;
                            fill_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and run-bookkeeping registers. The last-served zone resets to the
    // dripper, so the sprinkler wins the first contention.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            zone_q        <= ZONE_S;
            last_served_q <= ZONE_D;
            remaining_q   <= '0;
            fill_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            zone_q        <= zone_d;
            last_served_q <= last_served_d;
            remaining_q   <= remaining_d;
            fill_cnt_q    <= fill_cnt_d;
        end
    end

    // Moore outputs decoded from the state register. Reset therefore closes
    // every valve immediately, without waiting for a clock edge.
    assign fill_valve = (state_q == FILL);
    assign splinker   = (state_q == RUN_S);
    assign dripper    = (state_q == RUN_D);
    assign busy       = (state_q != IDLE);
    assign fault      = (state_q == FAULT);
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler
//
// Drives irrigation_scheduler through hand-computed scenarios, followed by a
// randomized phase. The bench keeps a reference model of the scheduling rules.
// A compare process checks every DUT output against that model on each
// falling clock edge.

module tb_irrigation_scheduler;

    localparam int TIME_W       = 8;
    localparam int FILL_TIMEOUT = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic              full_tank = 1'b0;
    logic              empty_tank = 1'b0;
    logic              splinker_req = 1'b0;
    logic              dripper_req = 1'b0;
    logic [TIME_W-1:0] splinker_time = '0;
    logic [TIME_W-1:0] dripper_time = '0;
    logic              abort = 1'b0;
    logic              fill_valve, splinker, dripper, busy, fault;
    logic [TIME_W-1:0] remaining;

    int checks   = 0;
    int failures = 0;
    bit cmpEn    = 1'b0;

    irrigation_scheduler #(
        .TIME_W      (TIME_W),
        .FILL_TIMEOUT(FILL_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .full_tank    (full_tank),
        .empty_tank   (empty_tank),
        .splinker_req (splinker_req),
        .dripper_req  (dripper_req),
        .splinker_time(splinker_time),
        .dripper_time (dripper_time),
        .abort        (abort),
        .fill_valve   (fill_valve),
        .splinker     (splinker),
        .dripper      (dripper),
        .busy         (busy),
        .remaining    (remaining),
        .fault        (fault)
    );

    // 10-unit clock period; rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // Reference model state.
    // mode: 0 idle, 1 filling, 2 running, 3 fault.
    // zone: 0 sprinkler, 1 dripper.
    int mMode, mZone, mLast, mRem, mFillTicks;
    int nMode, nZone, nLast, nRem, nFillTicks;
    bit wantS, wantD;

    // Advance the model by one clock edge, using the inputs applied for
    // that edge.
    always @(posedge clock or posedge reset) begin : refModel
        if (reset) begin
            mMode      <= 0;
            mZone      <= 0;
            mLast      <= 1;
            mRem       <= 0;
            mFillTicks <= 0;
        end else begin
            nMode      = mMode;
            nZone      = mZone;
            nLast      = mLast;
            nRem       = mRem;
            nFillTicks = mFillTicks;
            if (mMode == 3) begin
                nRem = 0;
            end else if (full_tank && empty_tank) begin
                nMode = 3;
                nRem  = 0;
            end else if (abort) begin
                if (mMode != 0) nLast = mZone;
                nMode = 0;
                nRem  = 0;
            end else if (mMode == 0) begin
                wantS = splinker_req && (int'(splinker_time) != 0);
                wantD = dripper_req && (int'(dripper_time) != 0);
                if (wantS || wantD) begin
                    nZone      = (wantS && wantD) ? (1 - mLast) : (wantS ? 0 : 1);
                    nRem       = (nZone == 0) ? int'(splinker_time) : int'(dripper_time);
                    nFillTicks = 0;
                    nMode      = full_tank ? 2 : 1;
                end
            end else if (mMode == 1) begin
                if (full_tank) begin
                    nMode = 2;
                end else if (tick) begin
                    nFillTicks = mFillTicks + 1;
                    if (nFillTicks >= FILL_TIMEOUT) begin
                        nMode = 3;
                        nRem  = 0;
                    end
                end
            end else begin
                if (tick) nRem = mRem - 1;
                if (tick && nRem == 0) begin
                    nMode = 0;
                    nLast = mZone;
                end else if (empty_tank) begin
                    nMode      = 1;
                    nFillTicks = 0;
                end
            end
            mMode      <= nMode;
            mZone      <= nZone;
            mLast      <= nLast;
            mRem       <= nRem;
            mFillTicks <= nFillTicks;
        end
    end

    // Count one comparison, and report it if the values differ.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model, once per cycle.
    always @(negedge clock) begin : compare
        if (cmpEn) begin
            checkOutput("model_fill_valve", int'(fill_valve), int'(mMode == 1));
            checkOutput("model_splinker", int'(splinker), int'(mMode == 2 && mZone == 0));
            checkOutput("model_dripper", int'(dripper), int'(mMode == 2 && mZone == 1));
            checkOutput("model_busy", int'(busy), int'(mMode != 0));
            checkOutput("model_fault", int'(fault), int'(mMode == 3));
            checkOutput("model_remaining", int'(remaining), mRem);
            checkOutput("valves_exclusive", int'(splinker && dripper), 0);
        end
    end

    // Move to just after the next falling edge, where inputs are safe to change.
    task automatic nextCycle();
        @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input bit fullT, input bit emptyT, input bit sReq, input bit dReq,
                                 input int sTime, input int dTime);
        full_tank     = fullT;
        empty_tank    = emptyT;
        splinker_req  = sReq;
        dripper_req   = dReq;
        splinker_time = TIME_W'(sTime);
        dripper_time  = TIME_W'(dTime);
    endtask

    task automatic applyReset();
        nextCycle();
        reset = 1'b1;
        tick  = 1'b0;
        abort = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    // Raise tick for exactly one rising clock edge.
    task automatic tickPulse();
        nextCycle();
        tick = 1'b1;
        nextCycle();
        tick = 1'b0;
    endtask

    task automatic waitBusy(input string name);
        int n;
        n = 0;
        while (!busy && n < 10) begin
            nextCycle();
            n++;
        end
        if (!busy) checkOutput(name, 0, 1);
    endtask

    int expOrder[3] = '{0, 1, 0};
    int zoneSeen;

    initial begin
        applyReset();
        cmpEn = 1'b1;

        // Reset state.
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_remaining", int'(remaining), 0);
        checkOutput("reset_fault", int'(fault), 0);

        // Single sprinkler run of 3 ticks, with a tick every 10 clocks.
        applyStimulus(1, 0, 1, 0, 3, 0);
        nextCycle();
        splinker_req = 1'b0;
        checkOutput("single_grant_valve", int'(splinker), 1);
        checkOutput("single_grant_rem", int'(remaining), 3);
        for (int k = 2; k >= 1; k--) begin
            repeat (8) nextCycle();
            tickPulse();
            checkOutput($sformatf("single_rem_%0d", k), int'(remaining), k);
            checkOutput("single_valve_on", int'(splinker), 1);
        end
        repeat (8) nextCycle();
        tickPulse();
        checkOutput("single_done_valve", int'(splinker), 0);
        checkOutput("single_done_busy", int'(busy), 0);
        checkOutput("single_done_rem", int'(remaining), 0);

        // Contention: the runs must alternate sprinkler, dripper, sprinkler.
        applyReset();
        applyStimulus(1, 0, 1, 1, 2, 2);
        for (int k = 0; k < 3; k++) begin
            waitBusy($sformatf("contention_start_%0d", k));
            zoneSeen = dripper ? 1 : 0;
            checkOutput($sformatf("contention_order_%0d", k), zoneSeen, expOrder[k]);
            tickPulse();
            tickPulse();
        end
        applyStimulus(1, 0, 0, 0, 0, 0);
        nextCycle();

        // Refill pause and resume during a dripper run.
        applyReset();
        applyStimulus(1, 0, 0, 1, 0, 5);
        nextCycle();
        dripper_req = 1'b0;
        checkOutput("refill_dripper_on", int'(dripper), 1);
        tickPulse();
        tickPulse();
        checkOutput("refill_rem_before", int'(remaining), 3);
        full_tank  = 1'b0;
        empty_tank = 1'b1;
        nextCycle();
        empty_tank = 1'b0;
        checkOutput("refill_fill_on", int'(fill_valve), 1);
        checkOutput("refill_dripper_off", int'(dripper), 0);
        checkOutput("refill_rem_held", int'(remaining), 3);
        repeat (3) tickPulse();
        checkOutput("refill_still_fill", int'(fill_valve), 1);
        full_tank = 1'b1;
        nextCycle();
        checkOutput("refill_resumed", int'(dripper), 1);
        checkOutput("refill_rem_resumed", int'(remaining), 3);
        tickPulse();
        tickPulse();
        checkOutput("refill_rem_last", int'(remaining), 1);
        tickPulse();
        checkOutput("refill_done", int'(busy), 0);

        // Fill timeout after FILL_TIMEOUT ticks without a full tank.
        applyReset();
        applyStimulus(0, 0, 1, 0, 5, 0);
        nextCycle();
        splinker_req = 1'b0;
        checkOutput("timeout_fill_on", int'(fill_valve), 1);
        repeat (FILL_TIMEOUT - 1) tickPulse();
        checkOutput("timeout_no_fault_yet", int'(fault), 0);
        tickPulse();
        checkOutput("timeout_fault", int'(fault), 1);
        checkOutput("timeout_fill_off", int'(fill_valve), 0);
        checkOutput("timeout_busy", int'(busy), 1);
        checkOutput("timeout_rem", int'(remaining), 0);
        abort     = 1'b1;
        full_tank = 1'b1;
        repeat (5) nextCycle();
        abort = 1'b0;
        checkOutput("timeout_fault_sticky", int'(fault), 1);

        // A zero-length request is ignored.
        applyReset();
        applyStimulus(1, 0, 1, 0, 0, 0);
        repeat (5) nextCycle();
        checkOutput("zero_time_idle", int'(busy), 0);
        checkOutput("zero_time_valve", int'(splinker), 0);

        // When a completing tick and an empty tank coincide, completion wins.
        applyReset();
        applyStimulus(1, 0, 1, 0, 1, 0);
        nextCycle();
        splinker_req = 1'b0;
        checkOutput("coincide_run", int'(splinker), 1);
        full_tank  = 1'b0;
        empty_tank = 1'b1;
        tick       = 1'b1;
        nextCycle();
        tick = 1'b0;
        checkOutput("coincide_idle", int'(busy), 0);
        checkOutput("coincide_no_fill", int'(fill_valve), 0);

        // Both level sensors active at once is a sensor fault.
        full_tank = 1'b1;
        nextCycle();
        checkOutput("both_sensors_fault", int'(fault), 1);

        // Abort during a sprinkler run.
        applyReset();
        applyStimulus(1, 0, 1, 0, 5, 0);
        nextCycle();
        splinker_req = 1'b0;
        tickPulse();
        checkOutput("abort_rem_before", int'(remaining), 4);
        abort = 1'b1;
        nextCycle();
        abort = 1'b0;
        checkOutput("abort_idle", int'(busy), 0);
        checkOutput("abort_rem", int'(remaining), 0);

        // Asynchronous reset during FILL closes the valve before the next edge.
        applyReset();
        applyStimulus(0, 0, 1, 0, 5, 0);
        nextCycle();
        splinker_req = 1'b0;
        checkOutput("async_fill_on", int'(fill_valve), 1);
        #1 reset = 1'b1;
        #1 checkOutput("async_fill_off", int'(fill_valve), 0);
        nextCycle();
        reset = 1'b0;

        // Randomized traffic, checked by the compare process.
        for (int c = 0; c < 4000; c++) begin
            nextCycle();
            reset = (fault && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 63) == 0) begin
                full_tank  = 1'b1;
                empty_tank = 1'b1;
            end else begin
                full_tank  = ($urandom_range(0, 2) != 0);
                empty_tank = !full_tank && ($urandom_range(0, 3) == 0);
            end
            splinker_req  = $urandom_range(0, 1) == 1;
            dripper_req   = $urandom_range(0, 1) == 1;
            splinker_time = TIME_W'($urandom_range(0, 4));
            dripper_time  = TIME_W'($urandom_range(0, 4));
            tick          = $urandom_range(0, 2) == 0;
            abort         = $urandom_range(0, 49) == 0;
        end
        nextCycle();
        nextCycle();
        cmpEn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
